// File: rtl/cep_din_pkg.sv
// Shared types for the CEP DIN write-port arbiter and its error-injection helper.
package cep_din_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        STALL  = 1'b1
    } din_arb_state_e;

    typedef enum logic {
        INJ_HW  = 1'b0,
        INJ_CPU = 1'b1
    } inj_target_e;

endpackage

// File: rtl/cep_err_inject.sv
// One-shot error injection: latches a target/check-bit pair on injArm and applies it
// to the first matching grant in a later cycle.
module cep_err_inject
    import cep_din_pkg::*;
#(
    parameter int CODE_PORT_WIDTH = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       injArm_i,
    input  logic                       injTarget_i,
    input  logic [CODE_PORT_WIDTH-1:0] injCheckBits_i,
    input  logic                       hwGrant_i,
    input  logic                       cpuGrant_i,
    output logic                       protOverride_o,
    output logic [CODE_PORT_WIDTH-1:0] checkBitsIn_o,
    output logic                       injDone_o
);

    logic                       armed_q;
    inj_target_e                target_q;
    logic [CODE_PORT_WIDTH-1:0] bits_q;
    logic                       prot_q;
    logic [CODE_PORT_WIDTH-1:0] cb_q;
    logic                       done_q;
    logic                       fire;

    // A fresh arm in this cycle masks any match so it lands on the next qualifying grant.
    always_comb begin
        fire = armed_q && !injArm_i &&
               (((target_q == INJ_HW) && hwGrant_i) || ((target_q == INJ_CPU) && cpuGrant_i));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            armed_q  <= 1'b0;
            target_q <= INJ_HW;
            bits_q   <= '0;
            prot_q   <= 1'b0;
            cb_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            if (injArm_i) begin
                armed_q  <= 1'b1;
                target_q <= inj_target_e'(injTarget_i);
                bits_q   <= injCheckBits_i;
            end else if (fire) begin
                armed_q <= 1'b0;
            end
            prot_q <= fire;
            cb_q   <= fire ? bits_q : '0;
            done_q <= fire;
        end
    end

    assign protOverride_o = prot_q;
    assign checkBitsIn_o  = cb_q;
    assign injDone_o      = done_q;

endmodule

// File: rtl/cep_din_arbiter.sv
// Hardware-priority arbiter for the shared DIN write port with bounded CPU wait.
// Optional one-shot error injection is built when CEP_ERR_INJECT_EN is defined.
module cep_din_arbiter
    import cep_din_pkg::*;
#(
    parameter int LOGICALWIDTH    = 32,
    parameter int ADDRWIDTH       = 10,
    parameter int CODE_PORT_WIDTH = 1,
    parameter int MAX_CPU_WAIT    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hwWe,
    input  logic [ADDRWIDTH-1:0]       hwAddr,
    input  logic [LOGICALWIDTH-1:0]    hwDin,
    output logic                       hwStall,
    output logic                       hwDropErr,
    input  logic                       cpuReq,
    input  logic [ADDRWIDTH-1:0]       cpuAddr,
    input  logic [LOGICALWIDTH-1:0]    cpuDin,
    output logic                       cpuAck,
    input  logic                       injArm,
    input  logic                       injTarget,
    input  logic [CODE_PORT_WIDTH-1:0] injCheckBits,
    output logic                       injDone,
    output logic                       memWe,
    output logic [ADDRWIDTH-1:0]       memAddr,
    output logic [LOGICALWIDTH-1:0]    hwUnprLogiDin,
    output logic [LOGICALWIDTH-1:0]    cpuUnprLogiDin,
    output logic                       hwActive,
    output logic                       protOverride,
    output logic [CODE_PORT_WIDTH-1:0] checkBitsIn
);

    localparam int CW = $clog2(MAX_CPU_WAIT + 1);

    din_arb_state_e          state_q, state_d;
    logic [CW-1:0]           waitCnt_q, waitCnt_d;
    logic                    hwGrant, cpuGrant, dropEvt;
    logic                    memWe_q, cpuAck_q, hwActive_q, dropErr_q;
    logic [ADDRWIDTH-1:0]    memAddr_q;
    logic [LOGICALWIDTH-1:0] hwDin_q, cpuDin_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= NORMAL;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // The stall cycle belongs to the CPU outright; any hardware write offered then is lost.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        hwGrant   = 1'b0;
        cpuGrant  = 1'b0;
        dropEvt   = 1'b0;
        unique case (state_q)
            NORMAL: begin
                hwGrant  = hwWe;
                cpuGrant = cpuReq && !hwWe;
                if (cpuReq && hwWe && (waitCnt_q == CW'(MAX_CPU_WAIT - 1)))
                    state_d = STALL;
            end
            STALL: begin
                cpuGrant = cpuReq;
                dropEvt  = hwWe;
                state_d  = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
        if (cpuGrant)
            waitCnt_d = '0;
        else if (cpuReq && (waitCnt_q != CW'(MAX_CPU_WAIT)))
            waitCnt_d = waitCnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            memWe_q    <= 1'b0;
            cpuAck_q   <= 1'b0;
            hwActive_q <= 1'b0;
            dropErr_q  <= 1'b0;
            memAddr_q  <= '0;
            hwDin_q    <= '0;
            cpuDin_q   <= '0;
        end else begin
            memWe_q   <= hwGrant || cpuGrant;
            cpuAck_q  <= cpuGrant;
            dropErr_q <= dropErr_q || dropEvt;
            if (hwGrant) begin
                memAddr_q  <= hwAddr;
                hwDin_q    <= hwDin;
                hwActive_q <= 1'b1;
            end else if (cpuGrant) begin
                memAddr_q  <= cpuAddr;
                cpuDin_q   <= cpuDin;
                hwActive_q <= 1'b0;
            end
        end
    end

    assign hwStall        = (state_q == STALL);
    assign hwDropErr      = dropErr_q;
    assign cpuAck         = cpuAck_q;
    assign memWe          = memWe_q;
    assign memAddr        = memAddr_q;
    assign hwUnprLogiDin  = hwDin_q;
    assign cpuUnprLogiDin = cpuDin_q;
    assign hwActive       = hwActive_q;

`ifdef CEP_ERR_INJECT_EN
    cep_err_inject #(
        .CODE_PORT_WIDTH(CODE_PORT_WIDTH)
    ) u_err_inject (
        .clk_i          (clk),
        .rst_i          (rst),
        .injArm_i       (injArm),
        .injTarget_i    (injTarget),
        .injCheckBits_i (injCheckBits),
        .hwGrant_i      (hwGrant),
        .cpuGrant_i     (cpuGrant),
        .protOverride_o (protOverride),
        .checkBitsIn_o  (checkBitsIn),
        .injDone_o      (injDone)
    );
`else
    logic unusedInj;
    assign unusedInj    = ^{injArm, injTarget, injCheckBits};
    assign protOverride = 1'b0;
    assign checkBitsIn  = '0;
    assign injDone      = 1'b0;
`endif

endmodule

// File: tb/tb_cep_din_arbiter.sv
// Scoreboard bench for cep_din_arbiter; injection expectations follow CEP_ERR_INJECT_EN.
module tb_cep_din_arbiter;

`ifdef CEP_ERR_INJECT_EN
    localparam bit INJ_EN = 1'b1;
`else
    localparam bit INJ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        hwWe, cpuReq, injArm, injTarget;
    logic [9:0]  hwAddr, cpuAddr, memAddr;
    logic [31:0] hwDin, cpuDin, hwUnprLogiDin, cpuUnprLogiDin;
    logic [0:0]  injCheckBits, checkBitsIn;
    logic        hwStall, hwDropErr, cpuAck, injDone, memWe, hwActive, protOverride;

    always #5 clk = ~clk;

    cep_din_arbiter #(
        .LOGICALWIDTH(32), .ADDRWIDTH(10), .CODE_PORT_WIDTH(1), .MAX_CPU_WAIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .hwWe(hwWe), .hwAddr(hwAddr), .hwDin(hwDin),
        .hwStall(hwStall), .hwDropErr(hwDropErr),
        .cpuReq(cpuReq), .cpuAddr(cpuAddr), .cpuDin(cpuDin), .cpuAck(cpuAck),
        .injArm(injArm), .injTarget(injTarget), .injCheckBits(injCheckBits),
        .injDone(injDone), .memWe(memWe), .memAddr(memAddr),
        .hwUnprLogiDin(hwUnprLogiDin), .cpuUnprLogiDin(cpuUnprLogiDin),
        .hwActive(hwActive), .protOverride(protOverride), .checkBitsIn(checkBitsIn)
    );

    typedef struct packed {
        logic        we;
        logic [9:0]  addr;
        logic        hw;
        logic [31:0] data;
        logic        ack;
        logic        stall;
        logic        prot;
        logic        cb;
        logic        done;
    } outv_t;

    outv_t sb[$];
    int    nCompared   = 0;
    int    nMismatched = 0;

    function automatic outv_t mkExp(bit we, bit hw, logic [9:0] a, logic [31:0] d, bit stall, bit inj);
        outv_t e;
        e       = '0;
        e.we    = we;
        e.addr  = we ? a : 10'h0;
        e.hw    = we && hw;
        e.data  = we ? d : 32'h0;
        e.ack   = we && !hw;
        e.stall = stall;
        e.prot  = inj && INJ_EN;
        e.cb    = inj && INJ_EN;
        e.done  = inj && INJ_EN;
        return e;
    endfunction

    function automatic outv_t observe();
        outv_t o;
        o.we    = memWe;
        o.addr  = memWe ? memAddr : 10'h0;
        o.hw    = memWe ? hwActive : 1'b0;
        o.data  = memWe ? (hwActive ? hwUnprLogiDin : cpuUnprLogiDin) : 32'h0;
        o.ack   = cpuAck;
        o.stall = hwStall;
        o.prot  = protOverride;
        o.cb    = checkBitsIn[0];
        o.done  = injDone;
        return o;
    endfunction

    task automatic drive(bit h, logic [9:0] ha, logic [31:0] hd, bit c, logic [9:0] ca, logic [31:0] cd);
        hwWe = h; hwAddr = ha; hwDin = hd;
        cpuReq = c; cpuAddr = ca; cpuDin = cd;
        injArm = 1'b0; injTarget = 1'b0; injCheckBits = 1'b0;
    endtask

    task automatic arm(bit tgt);
        injArm = 1'b1; injTarget = tgt; injCheckBits = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        outv_t got, expv;
        rst = 1'b1;
        drive(1, 10'h1AA, 32'h1234_5678, 1, 10'h0AA, 32'h8765_4321);
        arm(1);
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mkExp(0, 0, 0, 0, 0, 0));
            step();
            got = observe(); expv = sb.pop_front(); nCompared++;
            if (got !== expv) begin
                nMismatched++;
                $display("[TB] FAIL reset[%0d] observed=%h expected=%h", i, got, expv);
            end
        end
        nCompared++;
        if (hwDropErr !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_droperr observed=%b expected=0", hwDropErr);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_cpu_single();
        outv_t got, expv;
        for (int i = 0; i < 4; i++) begin
            case (i)
                1: begin
                    drive(0, 0, 0, 1, 10'h005, 32'hA5A5_A5A5);
                    sb.push_back(mkExp(1, 0, 10'h005, 32'hA5A5_A5A5, 0, 0));
                end
                2: begin
                    drive(1, 10'h3FF, 32'hDEAD_BEEF, 0, 0, 0);
                    sb.push_back(mkExp(1, 1, 10'h3FF, 32'hDEAD_BEEF, 0, 0));
                end
                default: begin
                    drive(0, 0, 0, 0, 0, 0);
                    sb.push_back(mkExp(0, 0, 0, 0, 0, 0));
                end
            endcase
            step();
            got = observe(); expv = sb.pop_front(); nCompared++;
            if (got !== expv) begin
                nMismatched++;
                $display("[TB] FAIL cpu_single[%0d] observed=%h expected=%h", i, got, expv);
            end
        end
    endtask

    // Continuous hardware traffic against a waiting CPU; holdHw keeps hwWe up in the stall cycle.
    task automatic test_stall(bit holdHw);
        outv_t got, expv;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                drive(1, 10'h010 + 10'(i), 32'h1000 + i, 1, 10'h020, 32'hCAFE_F00D);
                sb.push_back(mkExp(1, 1, 10'h010 + 10'(i), 32'h1000 + i, i == 3, 0));
            end else if (i == 4) begin
                drive(holdHw, 10'h055, 32'h5555, 1, 10'h020, 32'hCAFE_F00D);
                sb.push_back(mkExp(1, 0, 10'h020, 32'hCAFE_F00D, 0, 0));
            end else if (i == 5) begin
                drive(holdHw, 10'h056, 32'h5656, 0, 0, 0);
                sb.push_back(mkExp(holdHw, 1, 10'h056, 32'h5656, 0, 0));
            end else begin
                drive(0, 0, 0, 0, 0, 0);
                sb.push_back(mkExp(0, 0, 0, 0, 0, 0));
            end
            step();
            got = observe(); expv = sb.pop_front(); nCompared++;
            if (got !== expv) begin
                nMismatched++;
                $display("[TB] FAIL stall_hold%0d[%0d] observed=%h expected=%h", holdHw, i, got, expv);
            end
        end
        nCompared++;
        if (hwDropErr !== holdHw) begin
            nMismatched++;
            $display("[TB] FAIL stall_droperr observed=%b expected=%b", hwDropErr, holdHw);
        end
    endtask

    task automatic test_back_to_back();
        outv_t got, expv;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                drive(0, 0, 0, 1, 10'h100 + 10'(i), 32'hB000_0000 + i);
                sb.push_back(mkExp(1, 0, 10'h100 + 10'(i), 32'hB000_0000 + i, 0, 0));
            end else begin
                drive(0, 0, 0, 0, 0, 0);
                sb.push_back(mkExp(0, 0, 0, 0, 0, 0));
            end
            step();
            got = observe(); expv = sb.pop_front(); nCompared++;
            if (got !== expv) begin
                nMismatched++;
                $display("[TB] FAIL back_to_back[%0d] observed=%h expected=%h", i, got, expv);
            end
        end
    endtask

    task automatic test_inject();
        outv_t got, expv;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin drive(0, 0, 0, 0, 0, 0); arm(1);
                         sb.push_back(mkExp(0, 0, 0, 0, 0, 0)); end
                1, 2: begin drive(1, 10'h030 + 10'(i), 32'h3000 + i, 0, 0, 0);
                         sb.push_back(mkExp(1, 1, 10'h030 + 10'(i), 32'h3000 + i, 0, 0)); end
                3: begin drive(0, 0, 0, 1, 10'h033, 32'h3333);
                         sb.push_back(mkExp(1, 0, 10'h033, 32'h3333, 0, 1)); end
                4: begin drive(0, 0, 0, 1, 10'h034, 32'h3434);
                         sb.push_back(mkExp(1, 0, 10'h034, 32'h3434, 0, 0)); end
                5: begin drive(1, 10'h035, 32'h3535, 0, 0, 0); arm(0);
                         sb.push_back(mkExp(1, 1, 10'h035, 32'h3535, 0, 0)); end
                6: begin drive(0, 0, 0, 1, 10'h036, 32'h3636);
                         sb.push_back(mkExp(1, 0, 10'h036, 32'h3636, 0, 0)); end
                7: begin drive(1, 10'h037, 32'h3737, 0, 0, 0);
                         sb.push_back(mkExp(1, 1, 10'h037, 32'h3737, 0, 1)); end
                8: begin drive(1, 10'h038, 32'h3838, 0, 0, 0);
                         sb.push_back(mkExp(1, 1, 10'h038, 32'h3838, 0, 0)); end
                default: begin drive(0, 0, 0, 0, 0, 0);
                         sb.push_back(mkExp(0, 0, 0, 0, 0, 0)); end
            endcase
            step();
            got = observe(); expv = sb.pop_front(); nCompared++;
            if (got !== expv) begin
                nMismatched++;
                $display("[TB] FAIL inject[%0d] observed=%h expected=%h", i, got, expv);
            end
        end
    endtask

    // Reset lands in the stall cycle; the still-pending CPU must wait the full count again.
    task automatic test_reset_stall();
        outv_t got, expv;
        nCompared++;
        if (hwDropErr !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL droperr_sticky observed=%b expected=1", hwDropErr);
        end
        for (int i = 0; i < 11; i++) begin
            rst = (i == 4);
            if (i < 4 || (i >= 5 && i < 9)) begin
                drive(1, 10'h040 + 10'(i), 32'h4000 + i, 1, 10'h0C0, 32'hC0C0_C0C0);
                if (i == 0) arm(1);
                sb.push_back(mkExp(1, 1, 10'h040 + 10'(i), 32'h4000 + i, (i == 3) || (i == 8), 0));
            end else if (i == 4) begin
                drive(0, 0, 0, 1, 10'h0C0, 32'hC0C0_C0C0);
                sb.push_back(mkExp(0, 0, 0, 0, 0, 0));
            end else if (i == 9) begin
                drive(0, 0, 0, 1, 10'h0C0, 32'hC0C0_C0C0);
                sb.push_back(mkExp(1, 0, 10'h0C0, 32'hC0C0_C0C0, 0, 0));
            end else begin
                drive(0, 0, 0, 0, 0, 0);
                sb.push_back(mkExp(0, 0, 0, 0, 0, 0));
            end
            step();
            got = observe(); expv = sb.pop_front(); nCompared++;
            if (got !== expv) begin
                nMismatched++;
                $display("[TB] FAIL reset_stall[%0d] observed=%h expected=%h", i, got, expv);
            end
            if (i == 4) begin
                nCompared++;
                if (hwDropErr !== 1'b0) begin
                    nMismatched++;
                    $display("[TB] FAIL droperr_cleared observed=%b expected=0", hwDropErr);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_cpu_single();
        test_stall(1'b0);
        test_stall(1'b1);
        test_back_to_back();
        test_inject();
        test_reset_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
